lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
Shares the single LC-3 memory port between the instruction-fetch requester and the load/store (data) requester. Arbitrates round-robin, latches the winning request, drives the memory port until the memory signals ready (or a wait timeout expires), then returns read data with a one-cycle acknowledge. Sits between the control unit's fetch/MAR-MDR paths and the block-RAM/memory-mapped-IO port.

Parameters:
ADDR_W, 16, address width.
DATA_W, 16, data word width.
MAX_WAIT, 255, max cycles to wait for mem_ready per grant; 0 = no timeout.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
if_req  in  1  fetch request; level, held until if_ack.
if_addr  in  ADDR_W  fetch address (PC).
if_ack  out  1  one-cycle fetch completion pulse.
if_err  out  1  valid with if_ack; 1 = timeout.
if_rdata  out  DATA_W  fetched instruction; valid with if_ack, held until next if_ack.
d_req  in  1  data request; level, held until d_ack.
d_we  in  1  1 = store, 0 = load.
d_addr  in  ADDR_W  data address (MAR).
d_wdata  in  DATA_W  store data (MDR).
d_ack  out  1  one-cycle data completion pulse.
d_err  out  1  valid with d_ack; 1 = timeout.
d_rdata  out  DATA_W  load data; valid with d_ack, held until next d_ack.
mem_en  out  1  memory access active.
mem_we  out  1  memory write strobe (qualified by mem_en).
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1.
mem_ready  in  1  memory completes access this cycle.
busy  out  1  1 whenever state != IDLE.

Behaviour:
- States: IDLE, GRANT_F, GRANT_D, RESP. All outputs registered.
- Reset (rst_n=0, async): state=IDLE; every output 0 (incl. rdata regs, mem_*); last_grant=DATA; wait counter=0. Reset mid-transfer aborts silently — no ack issued.
- IDLE: samples if_req/d_req at clk edge. Only one set -> grant it. Both set -> grant the one != last_grant (first tie after reset goes to FETCH). Neither -> stay. On grant: latch addr/we/wdata (fetch forces we=0), update last_grant, clear counter.
- GRANT_F/GRANT_D: mem_en=1, mem_addr/mem_we/mem_wdata = latched values, constant for the whole state. Requester input changes ignored.
- Edge with mem_ready=1: capture mem_rdata into the granted port's rdata (stores capture 0), err=0, go to RESP.
- Edge with mem_ready=0: counter+1; if MAX_WAIT!=0 and counter reaches MAX_WAIT-1 on that edge (i.e. MAX_WAIT cycles elapsed), go to RESP with err=1, rdata=0.
- RESP: mem_en=0, mem_we=0; ack of granted port =1 for exactly this cycle, err valid; requests ignored; next state IDLE unconditionally.
- Min latency: req high at edge N -> mem_en at N+1 cycle; mem_ready same cycle -> ack in cycle N+2; IDLE cycle N+3.
- Requester must drop req in the cycle after ack; a req still high when sampled in IDLE is a new request.
- mem_ready outside GRANT_* is ignored. if_ack and d_ack are never high together.
- Fairness: with both continuously requesting, grants strictly alternate F,D,F,D.

Test Plan:
- Reset then if_req=1, if_addr=0x3000, mem_ready tied 1, mem_rdata=0x1234 -> mem_en high 1 cycle with mem_addr=0x3000, mem_we=0; if_ack pulse 2 cycles after req, if_rdata=0x1234, if_err=0.
- d_req store d_addr=0xFE06, d_wdata=0x0041, mem_ready after 3 wait cycles -> mem_we=1 for 4 cycles, addresses/data stable, single d_ack, d_rdata=0.
- if_req and d_req asserted in the same cycle and held, re-asserted after each ack -> grant order FETCH, DATA, FETCH, DATA; acks never overlap.
- MAX_WAIT=4, mem_ready held 0 -> mem_en exactly 4 cycles, then ack with err=1, rdata=0; next request completes normally.
- rst_n pulsed low during GRANT_D -> all outputs 0 immediately, no ack; post-reset tie goes to FETCH.
- d_addr/d_wdata changed mid-grant -> mem_addr/mem_wdata unchanged.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lc3_mem_arbiter
// Shares the single LC-3 memory port between the instruction-fetch requester
// and the load/store (data) requester. Requests are arbitrated round-robin in
// IDLE. The winner's address/write-enable/write-data are latched and held on
// the memory port until mem_ready (or the wait timeout). The result is then
// returned with a one-cycle acknowledge on the winner's port.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   if_req/if_addr                fetch request (level) and PC
//   if_ack/if_err/if_rdata        fetch completion pulse, timeout flag, data
//   d_req/d_we/d_addr/d_wdata     data request (level), store flag, MAR, MDR
//   d_ack/d_err/d_rdata           data completion pulse, timeout flag, data
//   mem_en/mem_we/mem_addr/
//   mem_wdata                     memory port command (all registered)
//   mem_rdata/mem_ready           memory read data and completion strobe
//   busy                          high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module lc3_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_F = 2'd1;
  localparam logic [1:0] S_GRANT_D = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  // The counter only has to reach MAX_WAIT-1; with no timeout it just wraps.
  localparam int               CNT_W      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT - 1);
  localparam bit               TIMEOUT_EN = (MAX_WAIT != 0);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              if_err_q, if_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic              done_s;
  logic              done_err_s;
  logic [DATA_W-1:0] done_rdata_s;

  // Decide whether the current grant ends on this edge, and with what result.
  always_comb begin
    done_s       = 1'b0;
    done_err_s   = 1'b0;
    done_rdata_s = {DATA_W{1'b0}};
    if (mem_ready) begin
      done_s       = 1'b1;
      done_err_s   = 1'b0;
      // Stores return zero so the data port never sees stale read data.
      done_rdata_s = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
    end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
      done_s       = 1'b1;
      done_err_s   = 1'b1;
    end else begin
      done_s       = 1'b0;
    end
  end

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    if_err_d     = if_err_q;
    if_rdata_d   = if_rdata_q;
    d_ack_d      = 1'b0;
    d_err_d      = d_err_q;
    d_rdata_d    = d_rdata_q;
    busy_d       = busy_q;

    case (state_q)
      S_IDLE: begin
        // Fetch wins when alone, or on a tie if data was granted last.
        if (if_req && (!d_req || (last_grant_q == GNT_DATA))) begin
          state_d      = S_GRANT_F;
          last_grant_d = GNT_FETCH;
          wait_cnt_d   = {CNT_W{1'b0}};
          mem_en_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = {DATA_W{1'b0}};
          busy_d       = 1'b1;
        end else if (d_req) begin
          state_d      = S_GRANT_D;
          last_grant_d = GNT_DATA;
          wait_cnt_d   = {CNT_W{1'b0}};
          mem_en_d     = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          busy_d       = 1'b1;
        end else begin
          state_d      = S_IDLE;
          busy_d       = 1'b0;
        end
      end

      S_GRANT_F, S_GRANT_D: begin
        if (done_s) begin
          state_d  = S_RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          busy_d   = 1'b1;
          if (state_q == S_GRANT_F) begin
            if_ack_d   = 1'b1;
            if_err_d   = done_err_s;
            if_rdata_d = done_rdata_s;
          end else begin
            d_ack_d    = 1'b1;
            d_err_d    = done_err_s;
            d_rdata_d  = done_rdata_s;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1'b1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d  = S_IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_DATA;
      wait_cnt_q   <= {CNT_W{1'b0}};
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= {DATA_W{1'b0}};
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= {DATA_W{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lc3_mem_arbiter
// Directed bench for lc3_mem_arbiter (MAX_WAIT=4). A small memory model
// answers each access after lat_cfg extra wait cycles and returns
// mem_addr ^ 16'h2234. Every request is pushed onto a scoreboard queue when
// it is driven; a negedge monitor pops and checks it when the ack appears,
// and checks grant address/direction and mid-grant port stability.
// ---------------------------------------------------------------------------
module tb_lc3_mem_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_ack, if_err, d_ack, d_err;
  logic [15:0] if_rdata, d_rdata;
  logic        mem_en, mem_we, mem_ready, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  lat_cfg;
  logic [7:0]  en_cnt;

  typedef struct {
    logic        port;   // 0 = fetch, 1 = data
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          len;    // expected number of mem_en cycles
  } txn_t;

  txn_t sb[$];
  int   tests = 0;
  int   fails = 0;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: ready in the (lat_cfg+1)-th cycle of an access.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      en_cnt <= 8'd0;
    else if (mem_en) en_cnt <= en_cnt + 8'd1;
    else             en_cnt <= 8'd0;
  end
  assign mem_ready = mem_en && (en_cnt == lat_cfg);
  assign mem_rdata = mem_addr ^ 16'h2234;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic we, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic err, input int len);
    txn_t t;
    t.port  = port;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.err   = err;
    t.len   = len;
    t.rdata = (we || err) ? 16'h0000 : (addr ^ 16'h2234);
    sb.push_back(t);
  endtask

  // Wait for n acks, dropping each req on its ack; with refire, re-raise the
  // acked request (new address) in the following idle cycle until n-2 acks.
  task automatic run_acks(input int n, input bit refire, input int budget, output int cyc);
    int got;
    bit re_f;
    bit re_d;
    got  = 0;
    cyc  = 0;
    re_f = 1'b0;
    re_d = 1'b0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (if_ack) begin if_req = 1'b0; got++; re_f = refire && (got <= n - 2); end
      if (d_ack)  begin d_req  = 1'b0; got++; re_d = refire && (got <= n - 2); end
      @(posedge clk); #1;
      if (re_f) begin
        re_f = 1'b0; if_addr = if_addr + 16'h0010;
        push(1'b0, 1'b0, if_addr, 16'h0000, 1'b0, 1); if_req = 1'b1;
      end
      if (re_d) begin
        re_d = 1'b0; d_addr = d_addr + 16'h0010;
        push(1'b1, d_we, d_addr, d_wdata, 1'b0, 1); d_req = 1'b1;
      end
    end
    chk("ack_count", 32'(got), 32'(n));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({mem_en, mem_we, if_ack, if_err, d_ack, d_err, busy}), 32'd0);
    chk({tag, "_mem"},  {mem_addr, mem_wdata}, 32'd0);
    chk({tag, "_rd"},   {if_rdata, d_rdata},   32'd0);
  endtask

  // Scoreboard monitor: grant contents, stability during grant, ack results.
  always @(negedge clk) begin : mon
    logic        prev_en;
    logic        prev_we;
    logic [15:0] prev_addr;
    logic [15:0] prev_wdata;
    txn_t        t;
    if (!rst_n) begin
      prev_en <= 1'b0;
    end else begin
      chk("ack_overlap", 32'(if_ack & d_ack), 32'd0);
      if (mem_en && prev_en) begin
        chk("hold_addr",  32'(mem_addr),  32'(prev_addr));
        chk("hold_we",    32'(mem_we),    32'(prev_we));
        chk("hold_wdata", 32'(mem_wdata), 32'(prev_wdata));
      end
      if (mem_en && !prev_en) begin
        if (sb.size() == 0) begin
          chk("grant_unexpected", 32'(mem_en), 32'd0);
        end else begin
          chk("grant_addr", 32'(mem_addr), 32'(sb[0].addr));
          chk("grant_we",   32'(mem_we),   32'(sb[0].we));
          if (sb[0].we) chk("grant_wdata", 32'(mem_wdata), 32'(sb[0].wdata));
        end
      end
      if (if_ack || d_ack) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", 32'(if_ack | d_ack), 32'd0);
        end else begin
          t = sb.pop_front();
          chk("ack_port", 32'(d_ack), 32'(t.port));
          chk("ack_err",   32'(t.port ? d_err : if_err),     32'(t.err));
          chk("ack_rdata", 32'(t.port ? d_rdata : if_rdata), 32'(t.rdata));
          chk("ack_len",   32'(en_cnt), 32'(t.len));
          chk("ack_state", 32'({busy, mem_en, mem_we}), 32'(3'b100));
        end
      end
      prev_en    <= mem_en;
      prev_we    <= mem_we;
      prev_addr  <= mem_addr;
      prev_wdata <= mem_wdata;
    end
  end

  initial begin
    int cyc;
    rst_n = 1'b0; if_req = 1'b0; if_addr = 16'h0000;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    lat_cfg = 8'd0;
    repeat (3) @(posedge clk); #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single fetch, zero wait: ack two cycles after the request is sampled.
    if_addr = 16'h3000;
    push(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0, 1);
    if_req = 1'b1;
    run_acks(1, 1'b0, 20, cyc);
    chk("fetch_latency", 32'(cyc), 32'd3);
    chk("fetch_rdata", 32'(if_rdata), 32'h1234);
    chk("fetch_ack_pulse", 32'({if_ack, if_err}), 32'd0);

    // Data load with one wait cycle.
    lat_cfg = 8'd1; d_we = 1'b0; d_addr = 16'h4000;
    push(1'b1, 1'b0, 16'h4000, 16'h0000, 1'b0, 2);
    d_req = 1'b1;
    run_acks(1, 1'b0, 20, cyc);
    chk("load_rdata", 32'(d_rdata), 32'h6234);

    // Store with three wait cycles; requester inputs change mid-grant.
    lat_cfg = 8'd3; d_we = 1'b1; d_addr = 16'hFE06; d_wdata = 16'h0041;
    push(1'b1, 1'b1, 16'hFE06, 16'h0041, 1'b0, 4);
    d_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_addr = 16'h1111; d_wdata = 16'hBEEF;
    @(negedge clk);
    chk("store_hold", {mem_addr, mem_wdata}, {16'hFE06, 16'h0041});
    chk("store_we", 32'({mem_en, mem_we}), 32'(2'b11));
    run_acks(1, 1'b0, 20, cyc);
    chk("store_rdata", 32'({d_rdata, d_err}), 32'd0);

    // Both requesting continuously: grants alternate F, D, F, D.
    lat_cfg = 8'd0; d_we = 1'b0; if_addr = 16'h3100; d_addr = 16'h5000;
    push(1'b0, 1'b0, 16'h3100, 16'h0000, 1'b0, 1);
    push(1'b1, 1'b0, 16'h5000, 16'h0000, 1'b0, 1);
    if_req = 1'b1; d_req = 1'b1;
    run_acks(4, 1'b1, 60, cyc);

    // Timeout: mem_ready never arrives, MAX_WAIT cycles then err ack.
    lat_cfg = 8'hFF; if_addr = 16'h3200;
    push(1'b0, 1'b0, 16'h3200, 16'h0000, 1'b1, MW);
    if_req = 1'b1;
    run_acks(1, 1'b0, 20, cyc);
    chk("timeout_result", 32'({if_rdata, if_err}), 32'd1);
    lat_cfg = 8'd0; if_addr = 16'h3300;
    push(1'b0, 1'b0, 16'h3300, 16'h0000, 1'b0, 1);
    if_req = 1'b1;
    run_acks(1, 1'b0, 20, cyc);
    chk("after_timeout_err", 32'(if_err), 32'd0);

    // Reset during a data grant: everything clears, no ack follows.
    lat_cfg = 8'hFF; d_we = 1'b0; d_addr = 16'h6000;
    push(1'b1, 1'b0, 16'h6000, 16'h0000, 1'b0, 1);
    d_req = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("pre_reset_grant", 32'({mem_en, busy}), 32'(2'b11));
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    d_req = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk); #1;
    chk("reset_no_ack", 32'({if_ack, d_ack, mem_en, busy}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First tie after reset goes to fetch.
    lat_cfg = 8'd0; if_addr = 16'h3400; d_addr = 16'h6100;
    push(1'b0, 1'b0, 16'h3400, 16'h0000, 1'b0, 1);
    push(1'b1, 1'b0, 16'h6100, 16'h0000, 1'b0, 1);
    if_req = 1'b1; d_req = 1'b1;
    run_acks(2, 1'b0, 30, cyc);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
